// File: rtl/qpi_psram_responder.sv
`timescale 1ns/1ps
// LY68L6400-style QPI PSRAM responder backed by an internal byte RAM, for controller loopback.
// Optional protocol checker: define PSRAM_RESP_PROTO_CHECK_EN to populate proto_err.
module qpi_psram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 6,
    parameter int unsigned PAGE_BITS   = 10
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    inout  wire  [3:0] mem_sio,
    output logic       qpi_mode,
    output logic [7:0] last_cmd,
    output logic       cmd_err,
    output logic [2:0] proto_err
);

    localparam int unsigned AW    = 24;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [AW-1:0] PAGE_MASK = AW'((64'd1 << PAGE_BITS) - 64'd1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    localparam logic [7:0] CMD_RSTEN  = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;
    localparam logic [7:0] CMD_READ   = 8'hEB;
    localparam logic [7:0] CMD_WRITE  = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [6:0]      shreg, shreg_d;
    logic [AW-1:0]   addr, addr_d;
    logic            is_read, is_read_d;
    logic            nib_lo, nib_lo_d;
    logic [3:0]      wr_hi, wr_hi_d;
    logic            rsten_armed, armed_d;
    logic            qpi_d;
    logic [7:0]      last_cmd_d;
    logic            cmd_err_d;
    logic            oe, oe_d;
    logic [3:0]      dout, dout_d;

    logic            ram_we_c;
    logic            cmd_done_c;
    logic [7:0]      cmd_byte_c;
    logic [7:0]      rd_byte_c;
    logic [AW-1:0]   addr_inc_c;

    logic [7:0]      ram [DEPTH];

    assign mem_sio = oe ? dout : 4'bzzzz;

    // Burst increment wraps inside the page; bits above the page are held.
    assign addr_inc_c = (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
    assign rd_byte_c  = ram[addr[ADDR_WIDTH-1:0]];

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            addr        <= '0;
            is_read     <= 1'b0;
            nib_lo      <= 1'b0;
            wr_hi       <= '0;
            rsten_armed <= 1'b0;
            qpi_mode    <= 1'b0;
            last_cmd    <= '0;
            cmd_err     <= 1'b0;
            oe          <= 1'b0;
            dout        <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            shreg       <= shreg_d;
            addr        <= addr_d;
            is_read     <= is_read_d;
            nib_lo      <= nib_lo_d;
            wr_hi       <= wr_hi_d;
            rsten_armed <= armed_d;
            qpi_mode    <= qpi_d;
            last_cmd    <= last_cmd_d;
            cmd_err     <= cmd_err_d;
            oe          <= oe_d;
            dout        <= dout_d;
        end
    end

    // Next-state, datapath and command decode; a high mem_ce always wins.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        shreg_d    = shreg;
        addr_d     = addr;
        is_read_d  = is_read;
        nib_lo_d   = nib_lo;
        wr_hi_d    = wr_hi;
        armed_d    = rsten_armed;
        qpi_d      = qpi_mode;
        last_cmd_d = last_cmd;
        cmd_err_d  = cmd_err;
        oe_d       = 1'b0;
        dout_d     = dout;
        ram_we_c   = 1'b0;
        cmd_done_c = 1'b0;
        cmd_byte_c = {shreg, mem_sio[0]};

        if (mem_ce) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            nib_lo_d = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_d    = CW'(1);
                    nib_lo_d = 1'b0;
                    if (qpi_mode) begin
                        shreg_d = {3'b000, mem_sio};
                        state_d = ST_CMD;
                    end else begin
                        shreg_d = {6'b000000, mem_sio[0]};
                        state_d = ST_SPI_CMD;
                    end
                end
                ST_SPI_CMD: begin
                    shreg_d = cmd_byte_c[6:0];
                    cnt_d   = cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        cmd_done_c = 1'b1;
                        state_d    = ST_IGNORE;
                    end
                end
                ST_CMD: begin
                    cmd_byte_c = {shreg[3:0], mem_sio};
                    cmd_done_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IGNORE;
                    if (cmd_byte_c == CMD_READ || cmd_byte_c == CMD_WRITE) begin
                        state_d   = ST_ADDR;
                        is_read_d = (cmd_byte_c == CMD_READ);
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr[AW-5:0], mem_sio};
                    cnt_d  = cnt + CW'(1);
                    if (cnt == CW'(5)) begin
                        addr_d[AW-1] = 1'b0;
                        cnt_d        = '0;
                        if (!is_read) begin
                            state_d = ST_WDATA;
                        end else if (WAIT_CYCLES == 0) begin
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == WAIT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    oe_d     = 1'b1;
                    dout_d   = nib_lo ? rd_byte_c[3:0] : rd_byte_c[7:4];
                    nib_lo_d = !nib_lo;
                    if (nib_lo) begin
                        addr_d = addr_inc_c;
                    end
                    // cnt saturates at 2 nibbles: marks that a full byte went out
                    if (cnt != CW'(2)) begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                ST_WDATA: begin
                    nib_lo_d = !nib_lo;
                    if (!nib_lo) begin
                        wr_hi_d = mem_sio;
                    end else begin
                        ram_we_c = 1'b1;
                        addr_d   = addr_inc_c;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (cmd_done_c) begin
                last_cmd_d = cmd_byte_c;
                armed_d    = (cmd_byte_c == CMD_RSTEN);
                case (cmd_byte_c)
                    CMD_RSTEN: begin
                        armed_d = 1'b1;
                    end
                    CMD_RST: begin
                        if (rsten_armed) begin
                            qpi_d = 1'b0;
                        end
                    end
                    CMD_QPI_EN: begin
                        if (qpi_mode) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            qpi_d = 1'b1;
                        end
                    end
                    CMD_QPI_EX: begin
                        if (qpi_mode) begin
                            qpi_d = 1'b0;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                    CMD_READ, CMD_WRITE: begin
                        if (!qpi_mode) begin
                            cmd_err_d = 1'b1;
                        end
                    end
                    default: begin
                        cmd_err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Backing RAM is deliberately left out of reset.
    always_ff @(posedge mem_clk) begin
        if (ram_we_c) begin
            ram[addr[ADDR_WIDTH-1:0]] <= {wr_hi, mem_sio};
        end
    end

`ifdef PSRAM_RESP_PROTO_CHECK_EN
    logic [2:0] proto_set_c;

    // [0] unarmed reset, [1] truncated cmd/addr phase, [2] read ended before a full byte.
    always_comb begin
        proto_set_c    = 3'b000;
        proto_set_c[0] = cmd_done_c && (cmd_byte_c == CMD_RST) && !rsten_armed;
        if (mem_ce) begin
            proto_set_c[1] = (state == ST_SPI_CMD) || (state == ST_CMD) || (state == ST_ADDR);
            proto_set_c[2] = (state == ST_WAIT) || ((state == ST_RDATA) && (cnt != CW'(2)));
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 3'b000;
        end else begin
            proto_err <= proto_err | proto_set_c;
        end
    end
`else
    assign proto_err = 3'b000;
`endif

endmodule
